// File: rtl/uart_load_ctl_if.sv
// Handshake bundle around the program loader: assembled UART words in,
// single-word DRAM writes out, checksum bytes out to the UART transmitter.
interface uart_load_ctl_if;
    logic        uart_word_ready;
    logic [15:0] uart_word;
    logic        dram_req;
    logic [24:0] dram_addr;
    logic [15:0] dram_data;
    logic        dram_done;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        tx_start_n;

    modport master (
        input  uart_word_ready, uart_word, dram_done, tx_ready,
        output dram_req, dram_addr, dram_data, tx_byte, tx_start_n
    );
    modport slave (
        output uart_word_ready, uart_word, dram_done, tx_ready,
        input  dram_req, dram_addr, dram_data, tx_byte, tx_start_n
    );
endinterface

// File: rtl/uart_load_ctl.sv
// Program-load stage: buffers UART words, writes them to DRAM at sequential
// addresses, keeps a running checksum and reports it over UART at load end.
module uart_load_ctl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [24:0] ADDR_BASE  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    uart_load_ctl_if.master bus,
    output logic [15:0]     word_count,
    output logic [15:0]     checksum,
    output logic            overflow,
    output logic            busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT
    } state_t;

    state_t state, state_nx;

    logic          load_q, rdy_q;
    logic          load_rise, load_fall, push, pop, push_ok, full;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pending, tx_seen_lo;
    logic [15:0]   snap;

    assign load_rise = load_en & ~load_q;
    assign load_fall = ~load_en & load_q;
    assign push      = bus.uart_word_ready & ~rdy_q & load_en;
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = (state == IDLE) & (count != '0) & ~load_rise;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok   = push & (load_rise | ~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            load_q <= load_en;
            rdy_q  <= bus.uart_word_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[load_rise ? '0 : wr_ptr] <= bus.uart_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (load_rise) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(push_ok);
            count  <= (AW+1)'(push_ok);
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (count != '0)                        state_nx = WR_REQ;
                        else if (load_fall | (pending & ~load_en)) state_nx = TX_HI;
            WR_REQ:     state_nx = WR_WAIT;
            WR_WAIT:    if (bus.dram_done)                      state_nx = IDLE;
            TX_HI:      if (bus.tx_ready)                       state_nx = TX_HI_WAIT;
            TX_HI_WAIT: if (tx_seen_lo & bus.tx_ready)          state_nx = TX_LO;
            TX_LO:      if (bus.tx_ready)                       state_nx = TX_LO_WAIT;
            TX_LO_WAIT: if (tx_seen_lo & bus.tx_ready)          state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
        if (load_rise) state_nx = IDLE;
    end

    always_comb begin
        bus.dram_req   = (state == WR_REQ) | (state == WR_WAIT);
        bus.tx_start_n = ~(((state == TX_HI) | (state == TX_LO)) & bus.tx_ready & ~load_rise);
        bus.tx_byte    = 8'h00;
        if (state == TX_HI) bus.tx_byte = snap[15:8];
        if (state == TX_LO) bus.tx_byte = snap[7:0];
        busy           = (state != IDLE) | (count != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dram_addr <= ADDR_BASE;
            bus.dram_data <= '0;
            word_count    <= '0;
            checksum      <= '0;
            overflow      <= 1'b0;
            pending       <= 1'b0;
            tx_seen_lo    <= 1'b0;
            snap          <= '0;
        end else if (load_rise) begin
            word_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
            pending    <= 1'b0;
            tx_seen_lo <= 1'b0;
        end else begin
            if (push & full & ~pop) overflow <= 1'b1;
            if (pop) begin
                bus.dram_data <= mem[rd_ptr];
                bus.dram_addr <= ADDR_BASE + 25'(word_count);
            end
            if ((state == WR_WAIT) & bus.dram_done) begin
                word_count <= word_count + 16'd1;
                checksum   <= checksum + bus.dram_data;
            end
            if (load_fall)                                  pending <= 1'b1;
            else if ((state == TX_LO_WAIT) & (state_nx == IDLE)) pending <= 1'b0;
            if ((state == IDLE) & (state_nx == TX_HI)) snap <= checksum;
            // Wait states need to see tx_ready drop before accepting its return.
            if ((state == TX_HI_WAIT) | (state == TX_LO_WAIT)) begin
                if (tx_seen_lo & bus.tx_ready) tx_seen_lo <= 1'b0;
                else if (!bus.tx_ready)        tx_seen_lo <= 1'b1;
            end else begin
                tx_seen_lo <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_load_ctl.sv
// Directed bench for uart_load_ctl: DRAM responder and TX monitor run on the
// falling edge; stimulus is driven 2 ns after each rising edge.
module tb_uart_load_ctl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] word_count, checksum;
    logic        overflow, busy;

    uart_load_ctl_if bus();

    uart_load_ctl #(.FIFO_DEPTH(8), .ADDR_BASE(25'd0)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .bus(bus.master),
        .word_count(word_count), .checksum(checksum), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        hold = 1'b0;
    int          cnt = 0;
    int          tx_bad = 0;
    logic [24:0] aq[$];
    logic [15:0] dq[$];
    logic [7:0]  txq[$];

    // DRAM model: completes each write 3 cycles after dram_req rises unless held.
    initial begin
        bus.dram_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.dram_done) begin
                bus.dram_done = 1'b0;
                cnt = 0;
            end else if (bus.dram_req) begin
                cnt++;
                if (cnt >= 3 && !hold) begin
                    bus.dram_done = 1'b1;
                    aq.push_back(bus.dram_addr);
                    dq.push_back(bus.dram_data);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst && !bus.tx_start_n) begin
                txq.push_back(bus.tx_byte);
                if (!bus.tx_ready) tx_bad++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push(input logic [15:0] w);
        bus.uart_word = w;
        bus.uart_word_ready = 1'b1;
        step(1);
        bus.uart_word_ready = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        load_en = 1'b0;
        hold = 1'b0;
        bus.uart_word_ready = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        aq.delete(); dq.delete(); txq.delete();
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (aq.size() < n && k < budget) begin @(negedge clk); k++; end
        checks++;
        if (aq.size() < n) begin
            errors++;
            $display("FAIL wait_writes: got %0d writes, expected %0d", aq.size(), n);
        end
        step(2);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (txq.size() < n && k < budget) begin @(negedge clk); k++; end
        checks++;
        if (txq.size() < n) begin
            errors++;
            $display("FAIL wait_tx: got %0d bytes, expected %0d", txq.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [83:0] obs;
        for (int i = 0; i < 4; i++) begin
            load_en = i[0];
            bus.uart_word_ready = i[1];
            bus.uart_word = 16'hA5A5 ^ 16'(i);
            bus.tx_ready = ~i[0];
            @(negedge clk);
            obs = {bus.dram_req, bus.dram_addr, bus.dram_data, bus.tx_byte, bus.tx_start_n,
                   word_count, checksum, overflow, busy};
            checks++;
            if (obs !== {1'b0, 25'd0, 16'd0, 8'd0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h expected req=0 addr=0 data=0 byte=0 start_n=1 cnt=0 sum=0 ovf=0 busy=0", i, obs);
            end
        end
        load_en = 1'b0;
        bus.uart_word_ready = 1'b0;
        bus.tx_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        step(2);
        checks++;
        if (bus.dram_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: dram_req=%b busy=%b expected 0 0", bus.dram_req, busy);
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] exp_d [3] = '{16'h1234, 16'h0001, 16'hFFFF};
        load_en = 1'b1;
        step(1);
        bus.uart_word = 16'h1234;
        bus.uart_word_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.dram_req !== 1'b0) begin errors++; $display("FAIL lat_before_edge: dram_req got %b expected 0", bus.dram_req); end
        @(posedge clk); #2;
        bus.uart_word_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.dram_req !== 1'b0) begin errors++; $display("FAIL lat_cycle1: dram_req got %b expected 0", bus.dram_req); end
        @(negedge clk);
        checks++;
        if ({bus.dram_req, bus.dram_addr, bus.dram_data} !== {1'b1, 25'd0, 16'h1234}) begin
            errors++;
            $display("FAIL lat_cycle2: req/addr/data got %b %h %h expected 1 0 1234", bus.dram_req, bus.dram_addr, bus.dram_data);
        end
        step(1);
        push(16'h0001);
        push(16'hFFFF);
        wait_writes(3, 200);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aq[i] !== 25'(i) || dq[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL basic_write[%0d]: got addr %h data %h expected addr %h data %h", i, aq[i], dq[i], i, exp_d[i]);
            end
        end
        checks++;
        if ({word_count, checksum, overflow} !== {16'd3, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL basic_totals: cnt %0d sum %h ovf %b expected 3 1234 0", word_count, checksum, overflow);
        end
    endtask

    task automatic test_report();
        bus.tx_ready = 1'b1;
        load_en = 1'b0;
        wait_tx(1, 50);
        checks++;
        if (txq.size() >= 1 && txq[0] !== 8'h12) begin errors++; $display("FAIL report_hi: got %h expected 12", txq[0]); end
        step(4);
        checks++;
        if (txq.size() != 1) begin errors++; $display("FAIL report_hi_once: got %0d strobes expected 1", txq.size()); end
        bus.tx_ready = 1'b0;
        step(2);
        bus.tx_ready = 1'b1;
        wait_tx(2, 50);
        checks++;
        if (txq.size() >= 2 && txq[1] !== 8'h34) begin errors++; $display("FAIL report_lo: got %h expected 34", txq[1]); end
        step(3);
        checks++;
        if (txq.size() != 2) begin errors++; $display("FAIL report_lo_once: got %0d strobes expected 2", txq.size()); end
        bus.tx_ready = 1'b0;
        step(2);
        bus.tx_ready = 1'b1;
        step(3);
        checks++;
        if (busy !== 1'b0 || bus.tx_start_n !== 1'b1) begin
            errors++;
            $display("FAIL report_done: busy %b start_n %b expected 0 1", busy, bus.tx_start_n);
        end
        checks++;
        if (tx_bad != 0) begin errors++; $display("FAIL tx_start_without_ready: got %0d expected 0", tx_bad); end
    endtask

    task automatic test_overflow();
        do_reset();
        hold = 1'b1;
        load_en = 1'b1;
        step(1);
        for (int i = 1; i <= 10; i++) push(16'h0100 + 16'(i));
        checks++;
        if (overflow !== 1'b1 || aq.size() != 0) begin
            errors++;
            $display("FAIL ovf_set: overflow %b writes %0d expected 1 0", overflow, aq.size());
        end
        hold = 1'b0;
        wait_writes(9, 300);
        step(20);
        checks++;
        if (aq.size() != 9) begin errors++; $display("FAIL ovf_write_count: got %0d expected 9", aq.size()); end
        for (int i = 0; i < 9 && i < aq.size(); i++) begin
            checks++;
            if (aq[i] !== 25'(i) || dq[i] !== 16'h0101 + 16'(i)) begin
                errors++;
                $display("FAIL ovf_write[%0d]: got addr %h data %h expected addr %h data %h", i, aq[i], dq[i], i, 16'h0101 + 16'(i));
            end
        end
        checks++;
        if ({word_count, checksum, overflow} !== {16'd9, 16'h092D, 1'b1}) begin
            errors++;
            $display("FAIL ovf_totals: cnt %0d sum %h ovf %b expected 9 092d 1", word_count, checksum, overflow);
        end
    endtask

    task automatic test_collision();
        do_reset();
        hold = 1'b1;
        load_en = 1'b1;
        step(1);
        for (int i = 1; i <= 9; i++) push(16'h0200 + 16'(i));
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL coll_full: overflow %b busy %b expected 0 1", overflow, busy);
        end
        hold = 1'b0;
        step(1);
        bus.uart_word = 16'h020A;
        bus.uart_word_ready = 1'b1;
        step(1);
        bus.uart_word_ready = 1'b0;
        step(1);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL coll_no_ovf: got %b expected 0", overflow); end
        wait_writes(10, 400);
        for (int i = 0; i < 10 && i < aq.size(); i++) begin
            checks++;
            if (dq[i] !== 16'h0201 + 16'(i)) begin
                errors++;
                $display("FAIL coll_write[%0d]: got %h expected %h", i, dq[i], 16'h0201 + 16'(i));
            end
        end
        checks++;
        if ({word_count, checksum, overflow} !== {16'd10, 16'h1437, 1'b0}) begin
            errors++;
            $display("FAIL coll_totals: cnt %0d sum %h ovf %b expected 10 1437 0", word_count, checksum, overflow);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        hold = 1'b1;
        load_en = 1'b1;
        step(1);
        push(16'hBEEF);
        step(2);
        checks++;
        if (bus.dram_req !== 1'b1) begin errors++; $display("FAIL mid_in_write: dram_req got %b expected 1", bus.dram_req); end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.dram_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: dram_req %b busy %b expected 0 0", bus.dram_req, busy);
        end
        hold = 1'b0;
        load_en = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);
        checks++;
        if ({word_count, busy, bus.dram_req, aq.size() == 0} !== {16'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_after: cnt %0d busy %b req %b writes %0d expected 0 0 0 0", word_count, busy, bus.dram_req, aq.size());
        end
    endtask

    initial begin
        bus.uart_word_ready = 1'b0;
        bus.uart_word = 16'h0000;
        bus.tx_ready = 1'b1;
        test_reset();
        test_basic_load();
        test_report();
        test_overflow();
        test_collision();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_load_ctl.md
Name: uart_load_ctl

Overview:
- Program-load stage between uart_sr (upstream, assembled 16-bit words) and sdram_ctl (downstream, single-word writes).
- Replaces the ad-hoc word counter and edge logic in the top level.
- Buffers incoming words in a small FIFO, issues one handshaked DRAM write per word at sequential addresses, and keeps a running checksum.
- When loading ends, reports the checksum to the host over uart_tx.

Parameters:
- FIFO_DEPTH, 8, word buffer entries; power of two, minimum 2.
- ADDR_BASE, 0, first DRAM word address written after a load starts.

Ports:
- clk  input  1  system clock (MAX10_CLK1_50 domain)
- rst  input  1  asynchronous active-low reset
- load_en  input  1  load mode select (SW[1]); held stable by user
- uart_word_ready  input  1  level from uart_sr, high while uart_word valid
- uart_word  input  16  assembled word
- dram_req  output  1  write request to sdram_ctl (drives refresh_data)
- dram_addr  output  25  write address
- dram_data  output  16  write data
- dram_done  input  1  sdram_ctl data_ready, single-cycle completion pulse
- tx_ready  input  1  uart_tx ready_to_send
- tx_byte  output  8  byte to transmit
- tx_start_n  output  1  active-low one-cycle send strobe
- word_count  output  16  words written to DRAM since load start
- checksum  output  16  sum of written words, mod 2^16
- overflow  output  1  sticky: a word was dropped because the FIFO was full
- busy  output  1  high in any state other than IDLE, or when the FIFO is non-empty

Behaviour:
- Reset (asynchronous, rst low):
  - Outputs: dram_req=0, dram_addr=ADDR_BASE, dram_data=0, tx_byte=0, tx_start_n=1, word_count=0, checksum=0, overflow=0, busy=0.
  - Internal: FIFO empty, FSM=IDLE, edge registers cleared (load_en history=0, uart_word_ready history=1).
  - Assertion mid-operation aborts immediately; any pending DRAM write or TX is abandoned.
- Edge detection: registered previous values of load_en and uart_word_ready; all state updates happen on clk posedge.
- Load start (load_en rising edge):
  - Clears word_count, checksum, overflow and the FIFO.
  - Forces FSM to IDLE; if dram_req was high, it drops.
- Push:
  - A uart_word_ready rising edge with load_en=1 writes uart_word into the FIFO.
  - FIFO full: the word is discarded and overflow is set.
  - Push with load_en=0 is ignored.
- Pop: occurs in the IDLE->WR_REQ transition. Push and pop in the same cycle leave occupancy unchanged, including when full (push accepted, no overflow).
- FSM states:
  - IDLE:
    - FIFO non-empty -> WR_REQ. Pops the head; dram_data=head; dram_addr=ADDR_BASE+word_count (zero-extended to 25 bits).
    - Else, on a load_en falling edge (or load_en low with a pending-report flag set by that edge) -> TX_HI.
  - WR_REQ: dram_req=1, addr and data held stable -> WR_WAIT next cycle.
  - WR_WAIT:
    - dram_req held at 1 until dram_done is sampled high.
    - Then: dram_req=0; word_count+=1 (wraps at 0xFFFF->0); checksum+=dram_data (mod 2^16) -> IDLE.
    - Latency: push to dram_req high is 2 cycles when the FIFO is empty and FSM is IDLE.
  - TX_HI:
    - Waits for tx_ready=1, then pulses tx_start_n=0 for exactly one cycle with tx_byte=checksum[15:8] -> TX_HI_WAIT.
    - The checksum is snapshotted on entry to TX_HI; later changes are ignored.
  - TX_HI_WAIT: waits for tx_ready to go 0 and then back to 1 -> TX_LO.
  - TX_LO / TX_LO_WAIT: same as TX_HI / TX_HI_WAIT with checksum[7:0] -> IDLE; the pending-report flag clears.
- FIFO ordering at load end: a load_en falling edge with a non-empty FIFO drains all words before the report is sent.
- tx_start_n is never low while tx_ready=0.

Test Plan:
- Reset/idle: hold rst low, toggle all inputs -> every output at its reset value; dram_req stays 0.
- Basic load: load_en 0->1, push 0x1234, 0x0001, 0xFFFF; dram_done pulses 3 cycles after each dram_req -> writes to addresses 0, 1, 2 in order; word_count=3; checksum=0x1234; overflow=0.
- Overflow: FIFO_DEPTH=8, dram_done held 0, push 10 words -> overflow=1. Release dram_done -> exactly 9 writes in total (the one in flight plus 8 buffered), with the data of words 1..9.
- Report: after the basic load, load_en 1->0 with tx_ready=1 -> tx_start_n low one cycle with tx_byte=0x12, then (after a tx_ready low/high cycle) one cycle with tx_byte=0x34; busy returns to 0.
- Push/pop collision: FIFO full, push in the same cycle as the IDLE pop -> occupancy stays 8, overflow stays 0, no word lost.
- Reset mid-write: assert rst while in WR_WAIT -> dram_req=0 asynchronously (before the next clk edge); after release, word_count=0 and FIFO empty.
